// File: rtl/chacha20_seq_pkg.sv
// Shared types and constants for the ChaCha20 character block sequencer.
package chacha20_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_LAUNCH    = 2'd2,
        ST_WAIT_CORE = 2'd3
    } seq_state_t;

    localparam logic [1:0] REG_STATUS      = 2'd0;
    localparam logic [1:0] REG_BLOCK_COUNT = 2'd1;
    localparam logic [1:0] REG_BYTE_COUNT  = 2'd2;
    localparam logic [1:0] REG_CONTROL     = 2'd3;

    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_SOFT_CLEAR_BIT = 1;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int BYTES_PER_BLOCK = 64;

endpackage

// File: rtl/chacha20_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words and strobes each
// finished (or zero-padded partial) word into the core's plaintext buffer.
module chacha20_byte_packer #(
    parameter int WORDS = chacha20_seq_pkg::WORDS_PER_BLOCK
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    input  logic        close,
    output logic [31:0] word_out,
    output logic [3:0]  word_idx,
    output logic        word_we
);
    import chacha20_seq_pkg::*;

    logic [1:0]  lane_reg;
    logic [31:0] asm_reg;
    logic [31:0] asm_next;
    logic [3:0]  idx_reg;
    logic [3:0]  idx_next;
    logic [31:0] word_out_reg;
    logic [3:0]  word_idx_reg;
    logic        word_we_reg;
    logic        word_full;
    logic        emit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign asm_next[8*gi +: 8] = (byte_valid && lane_reg == 2'(gi)) ?
                                         byte_in : asm_reg[8*gi +: 8];
        end
    endgenerate

    // A close with bytes pending in the current lane flushes the padded word.
    assign word_full = byte_valid && (lane_reg == 2'd3);
    assign emit      = word_full || (close && (byte_valid || lane_reg != 2'd0));
    assign idx_next  = (idx_reg == 4'(WORDS - 1)) ? 4'd0 : idx_reg + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_reg     <= 2'd0;
            asm_reg      <= '0;
            idx_reg      <= 4'd0;
            word_out_reg <= '0;
            word_idx_reg <= 4'd0;
            word_we_reg  <= 1'b0;
        end else if (clear) begin
            lane_reg     <= 2'd0;
            asm_reg      <= '0;
            idx_reg      <= 4'd0;
            word_out_reg <= '0;
            word_idx_reg <= 4'd0;
            word_we_reg  <= 1'b0;
        end else begin
            word_we_reg <= emit;
            if (emit) begin
                word_out_reg <= asm_next;
                word_idx_reg <= idx_reg;
            end
            if (emit || close) begin
                lane_reg <= 2'd0;
                asm_reg  <= '0;
            end else if (byte_valid) begin
                lane_reg <= lane_reg + 2'd1;
                asm_reg  <= asm_next;
            end
            if (close) begin
                idx_reg <= 4'd0;
            end else if (emit) begin
                idx_reg <= idx_next;
            end
        end
    end

    assign word_out = word_out_reg;
    assign word_idx = word_idx_reg;
    assign word_we  = word_we_reg;

endmodule

// File: rtl/chacha20_char_block_sequencer.sv
// Character-to-block sequencer for the ChaCha20 core with an Avalon-MM control slave.
// Optional WAIT_CORE watchdog enabled by defining CHACHA_SEQ_TIMEOUT_EN.
module chacha20_char_block_sequencer #(
    parameter int WORDS_PER_BLOCK = chacha20_seq_pkg::WORDS_PER_BLOCK,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        flush,
    output logic [31:0] word_out,
    output logic [3:0]  word_idx,
    output logic        word_we,
    output logic        blk_start,
    output logic [6:0]  blk_len,
    input  logic        core_done,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);
    import chacha20_seq_pkg::*;

    seq_state_t  state_reg;
    seq_state_t  state_next;
    logic        enable_reg;
    logic [6:0]  blk_bytes_reg;
    logic [6:0]  bytes_after;
    logic [31:0] block_count_reg;
    logic [31:0] byte_count_reg;
    logic        blk_start_reg;
    logic [6:0]  blk_len_reg;
    logic [31:0] readdata_reg;
    logic [31:0] rd_mux;
    logic        accept;
    logic        ctrl_write;
    logic        soft_clear;
    logic        block_close;
    logic        done_ok;
    logic        timeout_hit;
    logic        error_bit;
    logic        unused_writedata;

    assign char_ready  = enable_reg && (state_reg == ST_FILL);
    assign accept      = char_valid && char_ready;
    assign ctrl_write  = write && (address == REG_CONTROL);
    assign soft_clear  = ctrl_write && writedata[CTRL_SOFT_CLEAR_BIT];
    assign bytes_after = blk_bytes_reg + 7'(accept);
    assign done_ok     = (state_reg == ST_WAIT_CORE) && core_done;
    assign block_close = (state_reg == ST_FILL) && enable_reg && !soft_clear &&
                         ((bytes_after == 7'(BYTES_PER_BLOCK)) ||
                          (flush && bytes_after != 7'd0));
    assign unused_writedata = ^writedata[31:2];

`ifdef CHACHA_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_reg;
    logic          error_reg;

    assign timeout_hit = (state_reg == ST_WAIT_CORE) && !core_done &&
                         (timer_reg == TW'(TIMEOUT_CYCLES - 1));
    assign error_bit   = error_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_reg <= '0;
            error_reg <= 1'b0;
        end else if (soft_clear) begin
            timer_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            if (state_reg == ST_WAIT_CORE && !core_done && !timeout_hit) begin
                timer_reg <= timer_reg + 1'b1;
            end else begin
                timer_reg <= '0;
            end
            if (timeout_hit) begin
                error_reg <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign error_bit          = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (enable_reg) state_next = ST_FILL;
            ST_FILL:      if (block_close) state_next = ST_LAUNCH;
            ST_LAUNCH:    state_next = ST_WAIT_CORE;
            ST_WAIT_CORE: begin
                if (core_done) begin
                    state_next = enable_reg ? ST_FILL : ST_IDLE;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            default:      state_next = ST_IDLE;
        endcase
        if (soft_clear) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            REG_STATUS:      rd_mux = {22'd0, error_bit, blk_bytes_reg[5:0],
                                       (state_reg != ST_IDLE), state_reg};
            REG_BLOCK_COUNT: rd_mux = block_count_reg;
            REG_BYTE_COUNT:  rd_mux = byte_count_reg;
            REG_CONTROL:     rd_mux = {31'd0, enable_reg};
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            enable_reg      <= 1'b0;
            blk_bytes_reg   <= 7'd0;
            block_count_reg <= '0;
            byte_count_reg  <= '0;
            blk_start_reg   <= 1'b0;
            blk_len_reg     <= 7'd0;
            readdata_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            blk_start_reg <= (state_reg == ST_LAUNCH) && !soft_clear;
            // Length is captured on entry to LAUNCH so it is stable under blk_start.
            if (block_close) begin
                blk_len_reg <= bytes_after;
            end
            if (soft_clear) begin
                blk_bytes_reg   <= 7'd0;
                block_count_reg <= '0;
                byte_count_reg  <= '0;
            end else begin
                blk_bytes_reg   <= block_close ? 7'd0 : bytes_after;
                byte_count_reg  <= byte_count_reg + 32'(accept);
                if (done_ok) begin
                    block_count_reg <= block_count_reg + 32'd1;
                end
            end
            if (ctrl_write) begin
                enable_reg <= writedata[CTRL_ENABLE_BIT];
            end else if (timeout_hit) begin
                enable_reg <= 1'b0;
            end
            readdata_reg <= write ? 32'd0 : rd_mux;
        end
    end

    chacha20_byte_packer #(
        .WORDS(WORDS_PER_BLOCK)
    ) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (soft_clear),
        .byte_valid (accept && !soft_clear),
        .byte_in    (char_in),
        .close      (block_close),
        .word_out   (word_out),
        .word_idx   (word_idx),
        .word_we    (word_we)
    );

    assign blk_start = blk_start_reg;
    assign blk_len   = blk_len_reg;
    assign readdata  = readdata_reg;

endmodule

// File: tb/tb_chacha20_char_block_sequencer.sv
// Directed bench: a queue-based block model predicts word writes and launches per cycle.
module tb_chacha20_char_block_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  char_in = '0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        flush = 1'b0;
    logic [31:0] word_out;
    logic [3:0]  word_idx;
    logic        word_we;
    logic        blk_start;
    logic [6:0]  blk_len;
    logic        core_done = 1'b0;
    logic [1:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;

    chacha20_char_block_sequencer #(
        .WORDS_PER_BLOCK(16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .flush      (flush),
        .word_out   (word_out),
        .word_idx   (word_idx),
        .word_we    (word_we),
        .blk_start  (blk_start),
        .blk_len    (blk_len),
        .core_done  (core_done),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    typedef struct { int c; logic [3:0] idx; logic [31:0] data; } wexp_t;
    typedef struct { int c; int len; } lexp_t;

    wexp_t       wq[$];
    lexp_t       lq[$];
    logic [7:0]  m_blk[$];
    int          m_bytes = 0;
    int          m_blocks = 0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] obs_word [16];
    int          obs_len = 0;
    int          obs_launches = 0;
    logic [31:0] rd_val;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: bytes of the current block; words and launches are scheduled by cycle.
    task automatic push_word(input int p);
        int n, wi;
        logic [31:0] d;
        n  = m_blk.size();
        wi = (n - 1) / 4;
        d  = '0;
        for (int k = 0; k < 4; k++) begin
            if (wi * 4 + k < n) d[8*k +: 8] = m_blk[wi * 4 + k];
        end
        wq.push_back('{p, 4'(wi), d});
    endtask

    task automatic close_block(input int p);
        if (m_blk.size() == 0) return;
        if (m_blk.size() % 4 != 0) push_word(p);
        lq.push_back('{p + 1, m_blk.size()});
        m_blk.delete();
    endtask

    task automatic model_accept(input logic [7:0] b, input bit fl, input int p);
        m_blk.push_back(b);
        m_bytes++;
        if (m_blk.size() % 4 == 0) push_word(p);
        if (m_blk.size() == 64 || fl) close_block(p);
    endtask

    task automatic model_reset();
        wq.delete();
        lq.delete();
        m_blk.delete();
        m_bytes  = 0;
        m_blocks = 0;
    endtask

    // Per-cycle compare of the buffer-write and launch strobes against the model.
    always @(negedge clk) begin
        bit ew, el;
        if (reset_n) begin
            ew = (wq.size() > 0) && (wq[0].c == cyc);
            el = (lq.size() > 0) && (lq[0].c == cyc);
            chk("word_we", 32'(word_we), 32'(ew));
            chk("blk_start", 32'(blk_start), 32'(el));
            if (word_we) obs_word[word_idx] = word_out;
            if (blk_start) begin
                obs_len = int'(blk_len);
                obs_launches++;
            end
            if (ew) begin
                if (word_we) begin
                    chk("word_idx", 32'(word_idx), 32'(wq[0].idx));
                    chk("word_out", word_out, wq[0].data);
                end
                void'(wq.pop_front());
            end
            if (el) begin
                if (blk_start) chk("blk_len", 32'(blk_len), 32'(lq[0].len));
                void'(lq.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit fl);
        int n;
        n = 0;
        @(negedge clk);
        char_in = b;
        char_valid = 1'b1;
        flush = fl;
        while (!char_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) chk("char_ready_timeout", 32'(char_ready), 32'd1);
        else model_accept(b, fl, cyc + 1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic send_flush();
        @(negedge clk);
        flush = 1'b1;
        close_block(cyc + 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        writedata = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        write = 1'b0;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic core_pulse();
        @(negedge clk);
        core_done = 1'b1;
        m_blocks++;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) obs_word[i] = '0;
        #23;
        chk("rst_char_ready", 32'(char_ready), 32'd0);
        chk("rst_word_we", 32'(word_we), 32'd0);
        chk("rst_blk_start", 32'(blk_start), 32'd0);
        chk("rst_blk_len", 32'(blk_len), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd0, rd_val); chk("status_reset", rd_val, 32'h0);
        rd(2'd3, rd_val); chk("control_reset", rd_val, 32'h0);

        // Full block 0x00..0x3F
        wr(2'd3, 32'd1);
        rd(2'd0, rd_val); chk("status_fill", rd_val, 32'h5);
        for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
        wait_cycles(3);
        rd(2'd0, rd_val); chk("status_wait", rd_val, 32'h7);
        core_pulse();
        rd(2'd1, rd_val); chk("block_count_full", rd_val, 32'(m_blocks));
        chk("block_count_lit", rd_val, 32'd1);
        rd(2'd2, rd_val); chk("byte_count_full", rd_val, 32'(m_bytes));
        chk("byte_count_lit", rd_val, 32'd64);
        chk("word0_lit", obs_word[0], 32'h03020100);
        chk("word15_lit", obs_word[15], 32'h3F3E3D3C);
        chk("len64_lit", 32'(obs_len), 32'd64);
        chk("launches_1", 32'(obs_launches), 32'd1);

        // Partial flush
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        send_flush();
        wait_cycles(3);
        chk("partial_word_lit", obs_word[0], 32'h00434241);
        chk("len3_lit", 32'(obs_len), 32'd3);
        core_pulse();

        // Byte and flush together, then an empty flush
        send(8'h5A, 1'b1);
        wait_cycles(3);
        chk("same_cycle_word_lit", obs_word[0], 32'h0000005A);
        chk("len1_lit", 32'(obs_len), 32'd1);
        core_pulse();
        send_flush();
        wait_cycles(4);
        chk("empty_flush_no_launch", 32'(obs_launches), 32'd3);

        // Backpressure while waiting for the core
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b0);
        send(8'h64, 1'b1);
        wait_cycles(3);
        fork
            send(8'h77, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_char_ready", 32'(char_ready), 32'd0);
                end
                core_pulse();
            end
        join
        send(8'h78, 1'b0);
        send(8'h79, 1'b0);
        send(8'h7A, 1'b1);
        wait_cycles(3);
        chk("bp_word_lit", obs_word[0], 32'h7A797877);
        chk("len4_lit", 32'(obs_len), 32'd4);
        core_pulse();
        rd(2'd1, rd_val); chk("block_count_bp", rd_val, 32'(m_blocks));
        chk("block_count5_lit", rd_val, 32'd5);
        rd(2'd2, rd_val); chk("byte_count_bp", rd_val, 32'(m_bytes));
        chk("byte_count76_lit", rd_val, 32'd76);

        // Soft clear mid-block
        for (int i = 0; i < 20; i++) send(8'(i), 1'b0);
        wait_cycles(2);
        rd(2'd0, rd_val); chk("status_20_bytes", rd_val, 32'hA5);
        wr(2'd3, 32'd3);
        model_reset();
        wait_cycles(1);
        rd(2'd0, rd_val); chk("status_after_clear", rd_val, 32'h5);
        rd(2'd1, rd_val); chk("block_count_clear", rd_val, 32'd0);
        rd(2'd2, rd_val); chk("byte_count_clear", rd_val, 32'd0);
        rd(2'd3, rd_val); chk("control_enable", rd_val, 32'd1);

        // Asynchronous reset mid-block
        for (int i = 0; i < 8; i++) send(8'(i), 1'b0);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_char_ready", 32'(char_ready), 32'd0);
        chk("arst_word_we", 32'(word_we), 32'd0);
        chk("arst_word_out", word_out, 32'd0);
        chk("arst_word_idx", 32'(word_idx), 32'd0);
        chk("arst_blk_len", 32'(blk_len), 32'd0);
        chk("arst_readdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(4);
        chk("arst_no_launch", 32'(obs_launches), 32'd5);

        // Launch and never complete
        wr(2'd3, 32'd1);
        send(8'hAB, 1'b1);
        wait_cycles(25);
`ifdef CHACHA_SEQ_TIMEOUT_EN
        rd(2'd0, rd_val); chk("status_timeout", rd_val, 32'h200);
        rd(2'd3, rd_val); chk("control_timeout", rd_val, 32'd0);
        rd(2'd1, rd_val); chk("block_count_timeout", rd_val, 32'(m_blocks));
`else
        rd(2'd0, rd_val); chk("status_no_timeout", rd_val, 32'h7);
        core_pulse();
        rd(2'd1, rd_val); chk("block_count_late", rd_val, 32'(m_blocks));
`endif
        wait_cycles(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
